// File: rtl/qmac_pkg.sv
// qmac_pkg: shared constants and types for the qmac_seq block.
//   QMAC_N/QMAC_Q/QMAC_GUARD : default operand width, fraction bits, guard bits
//   PROD_W, ACC_W            : product and accumulator widths
//   RES_MAX, RES_MIN         : saturation bounds of the N-bit result
//   s1_t                     : S1 pipeline record {prod, last, valid}
package qmac_pkg;
  localparam int QMAC_N     = 16;
  localparam int QMAC_Q     = 12;
  localparam int QMAC_GUARD = 8;

  localparam int PROD_W = 2*QMAC_N;
  localparam int ACC_W  = 2*QMAC_N + QMAC_GUARD;

  localparam logic signed [QMAC_N-1:0] RES_MAX = {1'b0, {(QMAC_N-1){1'b1}}};
  localparam logic signed [QMAC_N-1:0] RES_MIN = {1'b1, {(QMAC_N-1){1'b0}}};

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              last;
    logic              valid;
  } s1_t;
endpackage

// File: rtl/qmac_seq_if.sv
// qmac_seq_if: operand stream in, result stream out, valid/ready on both.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the MAC block
interface qmac_seq_if
  import qmac_pkg::*;
#(
  parameter int N = QMAC_N
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] result;
  logic                overflow;

  modport master (
    output in_valid, in_last, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, in_last, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/qmac_round_sat.sv
// qmac_round_sat: combinational ACC_W -> N conversion of a Q-format sum.
//   sum : signed accumulator value (2Q fraction bits)
//   res : signed N-bit Q-format result, saturated
//   sat : the value had to be clamped
// With QMAC_ROUND_EN defined, rounds half up before the shift; otherwise
// floors via the arithmetic shift alone.
module qmac_round_sat #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [N-1:0]     res,
  output logic                    sat
);
  localparam logic signed [N-1:0] R_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] R_MIN = {1'b1, {(N-1){1'b0}}};

  // One extra bit so the rounding add can never wrap.
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shf;

`ifdef QMAC_ROUND_EN
  localparam logic signed [ACC_W:0] HALF = {{(ACC_W-Q+1){1'b0}}, 1'b1, {(Q-1){1'b0}}};
  assign rnd = {sum[ACC_W-1], sum} + HALF;
`else
  assign rnd = {sum[ACC_W-1], sum};
`endif

  assign shf = rnd >>> Q;

  always_comb begin
    sat = 1'b1;
    res = R_MAX;
    if (shf > R_MAX) begin
      res = R_MAX;
    end else if (shf < R_MIN) begin
      res = R_MIN;
    end else begin
      sat = 1'b0;
      res = shf[N-1:0];
    end
  end
endmodule

// File: rtl/qmac_seq.sv
// qmac_seq: pipelined signed Q-format multiply-accumulate.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_valid/in_ready/a/b/in_last operand stream,
//                out_valid/out_ready/result/overflow result stream
// S1 registers the exact product, S2 accumulates with guard bits (clamping
// and flagging on overflow), and the vector's last element loads the
// rounded/saturated output register. Optional macro: QMAC_ROUND_EN
// (round half up instead of floor). The S1 record width comes from
// qmac_pkg, so N/GUARD overrides must match the package.
module qmac_seq
  import qmac_pkg::*;
#(
  parameter int N     = QMAC_N,
  parameter int Q     = QMAC_Q,
  parameter int GUARD = QMAC_GUARD
) (
  input logic       clk,
  input logic       rst_n,
  qmac_seq_if.slave io
);
  localparam int PW = 2*N;
  localparam int AW = 2*N + GUARD;
  localparam logic signed [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};

  s1_t                 s1;
  logic signed [AW-1:0] acc;
  logic                 ovf_acc;
  logic                 out_valid;
  logic signed [N-1:0]  result;
  logic                 overflow;

  logic                 stall;
  logic signed [PW-1:0] mul;
  logic signed [AW:0]   sum_w;
  logic                 ovf_now;
  logic signed [AW-1:0] sum_c;
  logic signed [N-1:0]  rs_res;
  logic                 rs_sat;
  logic                 load;

  assign stall       = out_valid && !io.out_ready;
  assign io.in_ready = !stall;
  assign io.out_valid = out_valid;
  assign io.result    = result;
  assign io.overflow  = overflow;

  assign mul = $signed(io.a) * $signed(io.b);

  // One bit wider than acc: the top two bits disagree exactly on overflow.
  assign sum_w   = {acc[AW-1], acc} + {{(AW+1-PW){s1.prod[PW-1]}}, s1.prod};
  assign ovf_now = sum_w[AW] ^ sum_w[AW-1];
  assign sum_c   = ovf_now ? (sum_w[AW] ? A_MIN : A_MAX) : sum_w[AW-1:0];
  assign load    = s1.valid && s1.last;

  qmac_round_sat #(.N(N), .Q(Q), .ACC_W(AW)) u_round_sat (
    .sum (sum_c),
    .res (rs_res),
    .sat (rs_sat)
  );

  // S1: product register; in_ready == !stall, so a transfer is in_valid here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (!stall) begin
      s1.valid <= io.in_valid;
      if (io.in_valid) begin
        s1.prod <= mul;
        s1.last <= io.in_last;
      end
    end
  end

  // S2 accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (!stall) begin
      // Not stalled means either empty or being consumed this edge.
      out_valid <= load;
      if (s1.valid) begin
        if (s1.last) begin
          acc      <= '0;
          ovf_acc  <= 1'b0;
          result   <= rs_res;
          overflow <= ovf_acc | ovf_now | rs_sat;
        end else begin
          acc     <= sum_c;
          ovf_acc <= ovf_acc | ovf_now;
        end
      end
    end
  end
endmodule

// File: tb/tb_qmac_seq.sv
// tb_qmac_seq: directed scoreboard bench for qmac_seq (N=16, Q=12).
module tb_qmac_seq;
  import qmac_pkg::*;

  logic clk;
  logic rst_n;

  qmac_seq_if #(.N(16)) bus ();

  qmac_seq #(.N(16), .Q(12), .GUARD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Drive one pair and hold it until accepted; returns 1ns after the edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic l);
    int n;
    n = 0;
    bus.a        = x;
    bus.b        = y;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Result monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, bus.result}, {16'd0, e.res});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single element 1.5 * 2.0, with latency check
    push(16'h3000, 1'b0);
    send(16'h1800, 16'h2000, 1'b1);
    @(negedge clk);
    chk("lat_edge_t", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge_t1", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Signed product -1.0 * 0.5
    push(16'hF800, 1'b0);
    send(16'hF000, 16'h0800, 1'b1);

    // Saturation, then a clean vector back-to-back
    push(RES_MAX, 1'b1);
    send(16'h4000, 16'h4000, 1'b0);
    send(16'h4000, 16'h4000, 1'b0);
    send(16'h4000, 16'h4000, 1'b0);
    send(16'h4000, 16'h4000, 1'b1);
    push(16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b1);

    // Rounding vs truncation
`ifdef QMAC_ROUND_EN
    push(16'h0001, 1'b0);
    push(16'h0000, 1'b0);
`else
    push(16'h0000, 1'b0);
    push(16'hFFFF, 1'b0);
`endif
    send(16'h0001, 16'h0800, 1'b1);
    send(16'hFFFF, 16'h0800, 1'b1);
    drain();

    // Backpressure
    bus.out_ready = 1'b0;
    push(16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b1);
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.a        = 16'h1000;
    bus.b        = 16'h1000;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_result_stable", {16'd0, bus.result}, 32'h1000);
      chk("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(16'h3800, 1'b0);
    send(16'h1000, 16'h1000, 1'b0);
    send(16'h0800, 16'h1000, 1'b0);
    send(16'h1000, 16'h2000, 1'b1);
    drain();

    // Reset mid-vector
    send(16'h1000, 16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_result", {16'd0, bus.result}, 32'd0);
    chk("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b1);
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qmac_seq.md
# qmac_seq

Pipelined signed fixed-point multiply-accumulate for the CRNN datapath. It accepts a stream of Q-format operand pairs, accumulates their products at full precision across a vector delimited by `in_last`, and emits one rounded, saturated N-bit result per vector. It sits between the feature/weight fetch logic and the activation stage. It is the sequential, parametrised successor of the team's combinational Q-format multiplier, with these additions:

- true two's-complement products
- a guard-bit accumulator
- rounding
- valid/ready flow control
- per-vector overflow reporting

## Interface
- `N`, 16: operand and result width, signed two's complement.
- `Q`, 12: fractional bits of operands and result.
- `GUARD`, 8: extra integer bits in the accumulator above the 2N-bit product.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept a pair this cycle.
- `a`, `b`  in  N each: signed Q-format operands.
- `in_last`  in  1: the pair is the final element of the current vector.
- `out_valid`  out  1: `result` and `overflow` are valid.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  N: signed Q-format dot product.
- `overflow`  out  1: a saturation occurred anywhere in this vector.

## Operation
- A transfer occurs when `in_valid && in_ready` on a rising edge.
- Stage S1 registers `prod = $signed(a)*$signed(b)` (2N bits, exact), together with `p_valid` and `p_last`.
- Stage S2 holds `acc`, which is 2N+GUARD bits signed.
  - When `p_valid`: `sum = acc + sext(prod)`.
  - If `sum` exceeds the acc range, clamp it to acc max/min and set the sticky flag `ovf_acc`.
- When `p_valid && p_last`, the output stage is loaded as follows:
  - `r = round(sum) >>> Q` (arithmetic shift).
  - Saturate `r` to [-2^(N-1), 2^(N-1)-1].
  - `result` takes the saturated value.
  - `overflow` = `ovf_acc` OR saturation in this conversion.
  - In the same edge, `acc` and `ovf_acc` clear to 0.
- A single-element vector (`in_last` on the first pair) is legal.
- The stall condition is `stall = out_valid && !out_ready`.
  - While stalled, S1 and S2 hold and `in_ready = 0`.
  - Otherwise `in_ready = 1`.
- Output register:
  - `out_valid` clears on `out_valid && out_ready`, unless a new result is loaded on the same edge.
  - `out_valid` rises when a result is loaded.
  - `result` and `overflow` are stable while `out_valid && !out_ready`.
- Reset values:
  - `in_ready` 1 after reset.
  - `out_valid` 0.
  - `result` 0.
  - `overflow` 0.
  - `acc` 0, `ovf_acc` 0, `p_valid` 0.
- Reset mid-vector discards the partial accumulation. The first pair accepted after reset starts a new vector.

## Timing
- Latency: pair with `in_last` accepted at edge t → `out_valid` high after edge t+1 (2 cycles).
- Throughput: one pair per cycle without backpressure. Back-to-back vectors need no idle cycle.
- Backpressure is applied combinationally from `out_ready` to `in_ready`. No other combinational input-to-output path exists.

## Configuration
- `QMAC_ROUND_EN` defined: round half up. Add `1 << (Q-1)` to `sum` before the shift; saturation is checked after rounding.
- `QMAC_ROUND_EN` undefined: truncate, i.e. floor via arithmetic shift. No adder is inferred.

## Structure
- The shared package `qmac_pkg` holds:
  - localparams `PROD_W = 2*N` and `ACC_W = 2*N+GUARD`.
  - the `RES_MAX`/`RES_MIN` constants.
  - the typedef for the S1 record {prod, last, valid}.
- Sub-module `qmac_round_sat`: combinational rounding, shift and saturation from ACC_W to N, with a saturation flag. It is instantiated once in the output path.

## Test plan
Concrete values below assume N=16, Q=12.

- Single element: `a`=0x1800 (1.5), `b`=0x2000 (2.0), last → `result`=0x3000, `overflow`=0, `out_valid` 2 cycles after acceptance.
- Signed product: 0xF000 (−1.0) × 0x0800 (0.5), last → `result`=0xF800, `overflow`=0.
- Saturation: four pairs of 0x4000×0x4000 (4.0×4.0), last on the 4th → `result`=0x7FFF, `overflow`=1. The next vector 0x1000×0x1000 → 0x1000, `overflow`=0.
- Rounding: 0x0001×0x0800 → 0x0001 with `QMAC_ROUND_EN`, 0x0000 without. 0xFFFF×0x0800 → 0x0000 with, 0xFFFF without.
- Backpressure: hold `out_ready`=0 for 5 cycles with a result pending while driving 3 more pairs.
  - `in_ready`=0 throughout and no pair is lost.
  - `result` is stable.
  - After release, both vectors are delivered in order.
- Reset mid-vector: accept 2 pairs of 0x1000×0x1000, pulse `rst_n` low asynchronously, then send 0x1000×0x1000 with last → `result`=0x1000, and all outputs read 0 during reset.
